spi_master_n: RTL

- Parametrised SPI master; successor to the fixed 8-bit, external-clock, mode-0-only SPI block.
- Internal programmable SCK divider, all four CPOL/CPHA modes, MSB/LSB-first, configurable word width.
- Integrated multi-slave chip-select with burst hold.
- Sits between the CPU peripheral bus and external flash/SD/display devices.

---
 rtl/spi_master_n.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_n.sv
// -----------------------------------------------------------------------------
// spi_master_n
//   Parametrised SPI master with an internal SCK divider, all four CPOL/CPHA
//   modes, MSB/LSB-first bit order, configurable word width and integrated
//   multi-slave chip-select with burst hold.
//
// Handshake: start_i is a request that is taken only in a cycle where
//   busy_o=0. Taking it latches data_i and every configuration input. busy_o
//   rises on the next cycle and stays high for the whole transfer. A request
//   made while busy_o=1 is dropped, not queued. Completion is a one-cycle
//   done_o pulse, with busy_o already low, in the cycle where data_o takes the
//   received word. A new start_i in that done_o cycle is taken.
//
// Ports:
//   clk_i, rst_i       system clock, asynchronous active-high reset
//   start_i            transfer request
//   data_i             transmit word
//   div_i              SCK half period is div_i+1 clk_i cycles
//   cpol_i, cpha_i     SPI mode
//   lsb_first_i        bit order
//   cs_sel_i           slave select; values >= NUM_CS assert no chip select
//   cs_hold_i          keep the chip select low after this word (burst)
//   data_o, done_o     received word and its one-cycle update strobe
//   busy_o             transfer in progress
//   sck_o, sdo_o       serial clock and data out
//   sdi_i              serial data in
//   cs_n_o             active-low chip selects
// -----------------------------------------------------------------------------
module spi_master_n #(
   parameter int WIDTH  = 8,
   parameter int DIV_W  = 8,
   parameter int NUM_CS = 1,
   parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic              lsb_first_i,
   input  logic [CS_W-1:0]   cs_sel_i,
   input  logic              cs_hold_i,
   output logic [WIDTH-1:0]  data_o,
   output logic              done_o,
   output logic              busy_o,
   output logic              sck_o,
   output logic              sdo_o,
   input  logic              sdi_i,
   output logic [NUM_CS-1:0] cs_n_o
);

   localparam int EC_W = $clog2(2 * WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic              cpha_q, cpha_d;
   logic              lsb_q, lsb_d;
   logic              hold_q, hold_d;
   logic [WIDTH-1:0]  tx_q, tx_d;
   logic [WIDTH-1:0]  rx_q, rx_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [EC_W-1:0]   edge_q, edge_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              sck_q, sck_d;
   logic              sdo_q, sdo_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;

   logic              tick;
   logic [EC_W-1:0]   edge_nxt;
   logic              leading;
   logic              last_edge;
   logic              do_shift;
   logic              do_sample;

   // Next bit to drive: the shift register always keeps it at the end that
   // matches the selected bit order.
   function automatic logic first_bit(input logic [WIDTH-1:0] w, input logic lsb);
      return lsb ? w[0] : w[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w, input logic lsb);
      return lsb ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
   endfunction

   // Received bits enter from the opposite end so that after WIDTH samples the
   // word sits in the same order it was sent; loopback returns data_i unchanged.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r, input logic b,
                                                 input logic lsb);
      return lsb ? {b, r[WIDTH-1:1]} : {r[WIDTH-2:0], b};
   endfunction

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      cpha_d    = cpha_q;
      lsb_d     = lsb_q;
      hold_d    = hold_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      data_d    = data_q;
      edge_d    = edge_q;
      done_d    = 1'b0;
      busy_d    = busy_q;
      sck_d     = sck_q;
      sdo_d     = sdo_q;
      cs_n_d    = cs_n_q;
      do_shift  = 1'b0;
      do_sample = 1'b0;

      // The divider ticks once per half period: reload on zero, else count down.
      tick      = (cnt_q == '0);
      edge_nxt  = edge_q + 1'b1;
      leading   = edge_nxt[0];
      last_edge = (edge_nxt == EC_W'(2 * WIDTH));

      case (state_q)
         IDLE: begin
            // Tracking cpol_i here also puts SCK at the latched idle level on
            // accept, so no separate CPOL register is needed afterwards.
            sck_d = cpol_i;
            if (start_i && !busy_q) begin
               state_d = SETUP;
               busy_d  = 1'b1;
               div_d   = div_i;
               cnt_d   = div_i;
               cpha_d  = cpha_i;
               lsb_d   = lsb_first_i;
               hold_d  = cs_hold_i;
               edge_d  = '0;
               rx_d    = '0;
               // Re-selecting releases any chip select left low by a burst;
               // the same select simply stays low.
               cs_n_d  = '1;
               for (int i = 0; i < NUM_CS; i++) begin
                  if (cs_sel_i == CS_W'(i)) cs_n_d[i] = 1'b0;
               end
               if (!cpha_i) begin
                  // CPHA=0 needs the first bit valid before the first edge.
                  sdo_d = first_bit(data_i, lsb_first_i);
                  tx_d  = shift_out(data_i, lsb_first_i);
               end else begin
                  tx_d  = data_i;
               end
            end
         end

         SETUP: begin
            if (tick) begin
               cnt_d   = div_q;
               state_d = XFER;
            end else begin
               cnt_d   = cnt_q - 1'b1;
            end
         end

         XFER: begin
            if (tick) begin
               cnt_d  = div_q;
               sck_d  = ~sck_q;
               edge_d = edge_nxt;
               if (cpha_q) begin
                  do_shift  = leading;
                  do_sample = !leading;
               end else begin
                  do_sample = leading;
                  do_shift  = !leading && !last_edge;
               end
               if (last_edge) state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         HOLD: begin
            if (tick) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               data_d  = rx_q;
               if (!hold_q) cs_n_d = '1;
            end else begin
               cnt_d   = cnt_q - 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      if (do_shift) begin
         sdo_d = first_bit(tx_q, lsb_q);
         tx_d  = shift_out(tx_q, lsb_q);
      end
      if (do_sample) begin
         rx_d = shift_in(rx_q, sdi_i, lsb_q);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         hold_q  <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         data_q  <= '0;
         edge_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         sck_q   <= 1'b0;
         sdo_q   <= 1'b0;
         cs_n_q  <= '1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         hold_q  <= hold_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         data_q  <= data_d;
         edge_q  <= edge_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         sck_q   <= sck_d;
         sdo_q   <= sdo_d;
         cs_n_q  <= cs_n_d;
      end
   end

   assign data_o = data_q;
   assign done_o = done_q;
   assign busy_o = busy_q;
   assign sck_o  = sck_q;
   assign sdo_o  = sdo_q;
   assign cs_n_o = cs_n_q;

endmodule
